// File: rtl/call_stack_pkg.sv
// Shared types and defaults for the JSB/RET return-address stack.
package call_stack_pkg;

    typedef enum logic [1:0] {
        CS_NOP,
        CS_PUSH,
        CS_POP,
        CS_REPL
    } cs_op_t;

    localparam int CS_ADDR_W_DEF = 12;
    localparam int CS_DEPTH_DEF  = 8;

    function automatic cs_op_t cs_decode(input logic push, input logic pop);
        cs_op_t op;
        case ({push, pop})
            2'b10:   op = CS_PUSH;
            2'b01:   op = CS_POP;
            2'b11:   op = CS_REPL;
            default: op = CS_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/call_stack_regs.sv
// DEPTH x ADDR_W return-address register ring: one write port, one combinational read port.
module call_stack_regs
    import call_stack_pkg::*;
#(
    parameter int ADDR_W = CS_ADDR_W_DEF,
    parameter int DEPTH  = CS_DEPTH_DEF,
    parameter int PTR_W  = $clog2(CS_DEPTH_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [ADDR_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [ADDR_W-1:0] rdata
);

    logic [ADDR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/call_stack_ctrl.sv
// Hardware return-address stack for JSB/RET with fill tracking and sticky error flags.
// Build option: CALL_STACK_CIRCULAR_EN makes a push while full overwrite the oldest entry.
module call_stack_ctrl
    import call_stack_pkg::*;
#(
    parameter int ADDR_W = CS_ADDR_W_DEF,
    parameter int DEPTH  = CS_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [ADDR_W-1:0]        push_addr,
    output logic [ADDR_W-1:0]        top_addr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    cs_op_t            op;
    logic [PTR_W-1:0]  sp, sp_n, sp_top;
    logic [CNT_W-1:0]  count_n;
    logic              ovf_set, udf_set;
    logic              we;
    logic [PTR_W-1:0]  waddr;
    logic [ADDR_W-1:0] rdata;

    assign sp_top = sp - PTR_W'(1);
    assign empty  = (count == '0);
    assign full   = (count == FULL_CNT);
    // Popped entries stay in the ring, so an empty stack must mask the stale read.
    assign top_addr = empty ? '0 : rdata;

    call_stack_regs #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_regs (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata (push_addr),
        .raddr (sp_top),
        .rdata (rdata)
    );

    always_comb begin
        op      = cs_decode(push, pop);
        sp_n    = sp;
        count_n = count;
        we      = 1'b0;
        waddr   = sp;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        case (op)
            CS_PUSH: begin
                if (!full) begin
                    we      = 1'b1;
                    sp_n    = sp + PTR_W'(1);
                    count_n = count + CNT_W'(1);
                end else begin
                    ovf_set = 1'b1;
`ifdef CALL_STACK_CIRCULAR_EN
                    we      = 1'b1;
                    sp_n    = sp + PTR_W'(1);
`endif
                end
            end
            CS_POP: begin
                if (!empty) begin
                    sp_n    = sp_top;
                    count_n = count - CNT_W'(1);
                end else begin
                    udf_set = 1'b1;
                end
            end
            CS_REPL: begin
                we = 1'b1;
                if (!empty) begin
                    waddr = sp_top;
                end else begin
                    // Tail-call on an empty stack degrades to a push (never full here).
                    sp_n    = sp + PTR_W'(1);
                    count_n = count + CNT_W'(1);
                    udf_set = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp        <= sp_n;
            count     <= count_n;
            overflow  <= ovf_set | (overflow  & ~clr_err);
            underflow <= udf_set | (underflow & ~clr_err);
        end
    end

`ifndef SYNTHESIS
    depth_pow2_a: assert property (@(posedge clk) (DEPTH & (DEPTH - 1)) == 0)
        else $error("call_stack_ctrl: DEPTH must be a power of two");
`endif

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Self-checking bench for call_stack_ctrl: directed scenarios plus random traffic vs a queue model.
module tb_call_stack_ctrl;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              push = 1'b0;
    logic              pop = 1'b0;
    logic              clr_err = 1'b0;
    logic [ADDR_W-1:0] push_addr = '0;
    logic [ADDR_W-1:0] top_addr;
    logic [3:0]        count;
    logic              empty, full, overflow, underflow;

    int n_checks = 0;
    int n_pass   = 0;

    logic [ADDR_W-1:0] q[$];
    logic              m_ovf = 1'b0;
    logic              m_udf = 1'b0;

    call_stack_ctrl #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_addr (push_addr),
        .top_addr  (top_addr),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    function automatic logic [ADDR_W-1:0] m_top();
        return (q.size() == 0) ? '0 : q[q.size()-1];
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".count"},     32'(count),     32'(q.size()));
        check({tag, ".top"},       32'(top_addr),  32'(m_top()));
        check({tag, ".empty"},     32'(empty),     32'(q.size() == 0));
        check({tag, ".full"},      32'(full),      32'(q.size() == DEPTH));
        check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
    endtask

    task automatic model_step(input logic p, input logic o, input logic [ADDR_W-1:0] a,
                              input logic c);
        logic so = 1'b0, su = 1'b0;
        if (p && !o) begin
            if (q.size() < DEPTH) q.push_back(a);
            else begin
                so = 1'b1;
`ifdef CALL_STACK_CIRCULAR_EN
                void'(q.pop_front());
                q.push_back(a);
`endif
            end
        end else if (!p && o) begin
            if (q.size() > 0) void'(q.pop_back());
            else su = 1'b1;
        end else if (p && o) begin
            if (q.size() > 0) q[q.size()-1] = a;
            else begin
                q.push_back(a);
                su = 1'b1;
            end
        end
        m_ovf = so ? 1'b1 : (c ? 1'b0 : m_ovf);
        m_udf = su ? 1'b1 : (c ? 1'b0 : m_udf);
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic step(input string tag, input logic p, input logic o,
                        input logic [ADDR_W-1:0] a, input logic c);
        push = p; pop = o; push_addr = a; clr_err = c;
        #1;
        check({tag, ".top_pre"}, 32'(top_addr), 32'(m_top()));
        @(posedge clk);
        #1;
        model_step(p, o, a, c);
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        check_all("reset");
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // Reset mid-sequence, asserted between edges
        step("t1_push", 1, 0, 12'h010, 0);
        step("t1_push", 1, 0, 12'h020, 0);
        #2 rst = 1'b1;
        #1;
        q.delete();
        check("t1.count", 32'(count), 0);
        check("t1.empty", 32'(empty), 1);
        check("t1.top",   32'(top_addr), 0);
        check("t1.flags", 32'({overflow, underflow}), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // LIFO order
        step("t2_push", 1, 0, 12'h101, 0);
        step("t2_push", 1, 0, 12'h102, 0);
        step("t2_push", 1, 0, 12'h103, 0);
        check("t2.top3", 32'(top_addr), 32'h103);
        step("t2_pop", 0, 1, '0, 0);
        check("t2.top2", 32'(top_addr), 32'h102);
        step("t2_pop", 0, 1, '0, 0);
        step("t2_pop", 0, 1, '0, 0);
        check("t2.empty", 32'(empty), 1);

        // Underflow and clear priority
        step("t3_pop_empty", 0, 1, '0, 0);
        check("t3.udf", 32'(underflow), 1);
        step("t3_clr", 0, 0, '0, 1);
        check("t3.udf_clr", 32'(underflow), 0);
        step("t3_clr_pop", 0, 1, '0, 1);
        check("t3.udf_wins", 32'(underflow), 1);
        step("t3_clr2", 0, 0, '0, 1);

        // Full boundary
        for (int i = 0; i < DEPTH; i++) step("t4_fill", 1, 0, 12'(12'h200 + i), 0);
        check("t4.full", 32'(full), 1);
        step("t4_over", 1, 0, 12'h2FF, 0);
        check("t4.ovf", 32'(overflow), 1);
        check("t4.count", 32'(count), 8);
`ifdef CALL_STACK_CIRCULAR_EN
        check("t4.top", 32'(top_addr), 32'h2FF);
`else
        check("t4.top", 32'(top_addr), 32'h207);
        step("t4_repl_full", 1, 1, 12'h2EE, 0);
        check("t4.repl_top", 32'(top_addr), 32'h2EE);
`endif
        for (int i = 0; i < DEPTH; i++) step("t4_drain", 0, 1, '0, 0);
        step("t4_clr", 0, 0, '0, 1);

        // Simultaneous push+pop
        step("t5_push", 1, 0, 12'h300, 0);
        step("t5_push", 1, 0, 12'h301, 0);
        step("t5_repl", 1, 1, 12'h3AA, 0);
        check("t5.top", 32'(top_addr), 32'h3AA);
        check("t5.count", 32'(count), 2);
        step("t5_pop", 0, 1, '0, 0);
        check("t5.next", 32'(top_addr), 32'h300);
        step("t5_pop", 0, 1, '0, 0);
        step("t5_repl_empty", 1, 1, 12'h3BB, 0);
        check("t5.top_e", 32'(top_addr), 32'h3BB);
        check("t5.udf_e", 32'(underflow), 1);

        // Random traffic, biased so the stack visits both empty and full
        for (int n = 0; n < 1500; n++) begin
            int unsigned r = $urandom_range(99);
            int unsigned bias = ((n / 200) % 2 == 0) ? 55 : 25;
            logic p = (r < bias) || (r >= 90);
            logic o = (r >= bias && r < 85) || (r >= 90);
            logic c = ($urandom_range(19) == 0);
            step("rnd", p, o, 12'($urandom), c);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
